led_fader: RTL and testbench



---
 rtl/led_fader_pkg.sv | 20 ++
 rtl/led_fader_channel.sv | 98 +++++++++
 rtl/led_fader.sv | 59 +++++
 tb/tb_led_fader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// Shared types and defaults for the LED fader: channel state encoding,
// brightness ceiling helper and default PWM/fade parameters.
package led_fader_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  localparam int N_LEDS_DEF   = 5;
  localparam int PWM_BITS_DEF = 8;
  localparam int FADE_DIV_DEF = 1024;

  function automatic int bmax(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: OFF/RISE/ON/FALL fade FSM, brightness register, duty curve
// and registered PWM compare. Define LED_FADER_GAMMA_EN for a squared duty curve.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                in_i,
  output logic                led_o,
  output logic                active_o
);

  localparam logic [PWM_BITS-1:0] BMAX = PWM_BITS'(bmax(PWM_BITS));
  localparam logic [PWM_BITS-1:0] BZERO = '0;

  fade_state_t         state_q;
  logic [PWM_BITS-1:0] b_q;
  logic [PWM_BITS-1:0] duty;
  logic                led_q;

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] duty_curve(input logic [PWM_BITS-1:0] b);
    logic [2*PWM_BITS-1:0] sq;
    sq = (2*PWM_BITS)'(b) * (2*PWM_BITS)'(b);
    return PWM_BITS'(sq >> PWM_BITS);
  endfunction
`else
  function automatic logic [PWM_BITS-1:0] duty_curve(input logic [PWM_BITS-1:0] b);
    return b;
  endfunction
`endif

  assign duty = duty_curve(b_q);

  // Direction changes win over a coincident tick; the b == BMAX / b == 0
  // guards cover a reversal that lands exactly on an end point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      b_q     <= '0;
    end else begin
      case (state_q)
        OFF: begin
          b_q <= '0;
          if (in_i) state_q <= RISE;
        end
        RISE: begin
          if (!in_i) begin
            state_q <= FALL;
          end else if (b_q == BMAX) begin
            state_q <= ON;
          end else if (tick_i) begin
            b_q <= b_q + 1'b1;
            if (b_q == BMAX - 1'b1) state_q <= ON;
          end
        end
        ON: begin
          b_q <= BMAX;
          if (!in_i) state_q <= FALL;
        end
        FALL: begin
          if (in_i) begin
            state_q <= RISE;
          end else if (b_q == BZERO) begin
            state_q <= OFF;
          end else if (tick_i) begin
            b_q <= b_q - 1'b1;
            if (b_q == PWM_BITS'(1)) state_q <= OFF;
          end
        end
        default: begin
          state_q <= OFF;
          b_q     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 1'b0;
    end else if (b_q == BZERO) begin
      led_q <= 1'b0;
    end else if (b_q == BMAX) begin
      led_q <= 1'b1;
    end else begin
      led_q <= (pwm_cnt_i < duty);
    end
  end

  assign led_o    = led_q;
  assign active_o = (state_q == RISE) || (state_q == FALL);

endmodule

// File: rtl/led_fader.sv
// LED fader top: input register, shared fade prescaler and PWM counter,
// one fade channel per LED and registered busy flag. Optional LED_FADER_GAMMA_EN.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int N_LEDS   = N_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] in_level,
  output logic [N_LEDS-1:0] led,
  output logic              busy
);

  localparam int PRE_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0]    presc_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [N_LEDS-1:0]   in_q;
  logic [N_LEDS-1:0]   active;
  logic                busy_q;
  logic                tick;

  assign tick = (presc_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      in_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      pwm_q   <= pwm_q + 1'b1;
      in_q    <= in_level;
      busy_q  <= |active;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .pwm_cnt_i(pwm_q),
      .in_i     (in_q[i]),
      .led_o    (led[i]),
      .active_o (active[i])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader (PWM_BITS=4, BMAX=15): a fast instance
// (FADE_DIV=4) and a slow one (FADE_DIV=64) used for steady-duty windows.
module tb_led_fader;

  typedef struct {
    string name;
    int    cyc;
    int    kind;  // 0 busy, 1 led bit, 2 fast window, 3 slow window, 4 led vector
    int    ch;
    int    expv;
  } exp_t;

`ifdef LED_FADER_GAMMA_EN
  localparam bit GAM = 1'b1;
`else
  localparam bit GAM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_level = 5'h1F;
  logic [4:0] led_f, led_s;
  logic       busy_f, busy_s;

  int   cyc = 0;
  int   R = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic [4:0] hist_f [4096];
  logic [4:0] hist_s [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_fader #(.N_LEDS(5), .PWM_BITS(4), .FADE_DIV(4)) u_fast (
    .clk(clk), .rst(rst), .in_level(in_level), .led(led_f), .busy(busy_f));

  led_fader #(.N_LEDS(5), .PWM_BITS(4), .FADE_DIV(64)) u_slow (
    .clk(clk), .rst(rst), .in_level(in_level), .led(led_s), .busy(busy_s));

  // Monitor: samples on the falling edge and retires due scoreboard entries.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    hist_f[cyc & 4095] = led_f;
    hist_s[cyc & 4095] = led_s;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: check at cycle %0d skipped (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = 0;
        case (e.kind)
          0: act = int'(busy_f);
          1: act = int'(led_f[e.ch]);
          2: for (int j = 0; j < 16; j++) act += int'(hist_f[(cyc - j) & 4095][e.ch]);
          3: for (int j = 0; j < 16; j++) act += int'(hist_s[(cyc - j) & 4095][e.ch]);
          default: act = int'(led_f);
        endcase
        if (act !== e.expv) begin
          n_bad++;
          $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.expv);
        end
      end
    end
  end

  task automatic expect_abs(input string name, input int c, input int kind,
                            input int ch, input int v);
    sb.push_back('{name, c, kind, ch, v});
  endtask

  task automatic expect_rel(input string name, input int rel, input int kind,
                            input int ch, input int v);
    expect_abs(name, R + rel, kind, ch, v);
  endtask

  task automatic apply_reset(input int n, input logic [4:0] lvl);
    rst = 1'b1;
    in_level = lvl;
    repeat (n) @(posedge clk);
    #1;
    R = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    while (cyc < R + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Phase A: reset with all requests high, then all channels rise together.
    for (int i = 1; i <= 3; i++) begin
      expect_abs("rst_led", i, 4, 0, 0);
      expect_abs("rst_busy", i, 0, 0, 0);
    end
    apply_reset(3, 5'h1F);
    expect_rel("busy_rel1", 1, 0, 0, 0);
    expect_rel("busy_rel2", 2, 0, 0, 0);
    expect_rel("busy_rise", 3, 0, 0, 1);
    expect_rel("all_b5_pwm4", 21, 4, 0, GAM ? 0 : 31);
    expect_rel("busy_midfade", 29, 0, 0, 1);
    expect_rel("midrst_led", 30, 4, 0, 0);
    expect_rel("midrst_busy", 30, 0, 0, 0);
    wait_rel(29);

    // Phase B: full rise of channel 0 (reset asserted here lands mid-fade).
    apply_reset(3, 5'h00);
    in_level = 5'h01;
    expect_rel("b_busy_on", 3, 0, 0, 1);
    expect_rel("b_led0_b5_pwm4", 21, 1, 0, GAM ? 0 : 1);
    expect_rel("b_led0_b5_pwm5", 22, 1, 0, 0);
    expect_rel("b_busy_last", 60, 0, 0, 1);
    expect_rel("b_busy_done", 61, 0, 0, 0);
    expect_rel("b_led_vec_full", 62, 4, 0, 1);
    expect_rel("b_led0_full_win", 77, 2, 0, 16);
    wait_rel(78);

    // Phase C: channel 1 reverses after 20 cycles, peaks at b=5, fades to OFF.
    apply_reset(3, 5'h00);
    in_level = 5'h02;
    expect_rel("c_busy_on", 3, 0, 0, 1);
    expect_rel("c_led1_peak", 21, 1, 1, GAM ? 0 : 1);
    expect_rel("c_busy_fall", 30, 0, 0, 1);
    expect_rel("c_led1_b2_pwm0", 33, 1, 1, GAM ? 0 : 1);
    expect_rel("c_led1_b2_pwm2", 35, 1, 1, 0);
    expect_rel("c_busy_last", 40, 0, 0, 1);
    expect_rel("c_busy_off", 41, 0, 0, 0);
    expect_rel("c_led1_off_win", 57, 2, 1, 0);
    wait_rel(20);
    in_level = 5'h00;
    wait_rel(58);

    // Phase D: slow instance holds each b for 64 cycles; count duty windows.
    apply_reset(3, 5'h00);
    in_level = 5'h01;
    expect_rel("d_duty_b1", 85, 3, 0, GAM ? 0 : 1);
    expect_rel("d_duty_b5", 345, 3, 0, GAM ? 1 : 5);
    expect_rel("d_duty_b8", 535, 3, 0, GAM ? 4 : 8);
    expect_rel("d_off_ch1", 600, 3, 1, 0);
    expect_rel("d_fast_full", 700, 2, 0, 16);
    expect_rel("d_duty_b15", 985, 3, 0, 16);
    wait_rel(990);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
